// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: frame states, widths,
// parity-type encoding and the 2-of-3 majority helper.
package uart_pkg;

  localparam int DATA_W     = 8;
  localparam int PRESCALE_W = 6;
  localparam int BIT_CNT_W  = $clog2(DATA_W);

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Line, configuration and result signals of the UART receiver.
// The receiver sits on the slave side; the line driver and consumer sit on the master side.
interface uart_rx_if;
  import uart_pkg::*;

  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESCALE_W-1:0] prescale;
  logic [DATA_W-1:0]     P_DATA;
  logic                  DATA_VLD;
  logic                  STR_ERR;
  logic                  PAR_ERR;
  logic                  STP_ERR;

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, prescale,
    output P_DATA, DATA_VLD, STR_ERR, PAR_ERR, STP_ERR
  );

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, prescale,
    input  P_DATA, DATA_VLD, STR_ERR, PAR_ERR, STP_ERR
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Bit timing for the UART receiver: edge counter within a bit, data-bit counter,
// and a 3-point majority vote around mid-bit.
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  data_phase,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  sampled_bit,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]            samples_q, samples_d;
  logic [PRESCALE_W-1:0] half;
  logic                  last_edge;

  always_comb begin
    // NOTE: every value driven here gets a default before any branch, so no path infers a latch.
    half       = prescale >> 1;
    last_edge  = (edge_cnt_q == prescale - PRESCALE_W'(1));
    edge_cnt_d = '0;
    bit_cnt_d  = bit_cnt_q;
    samples_d  = samples_q;

    if (run) begin
      edge_cnt_d = last_edge ? '0 : edge_cnt_q + PRESCALE_W'(1);
      if (edge_cnt_q == half - PRESCALE_W'(1)) samples_d[0] = rx_in;
      if (edge_cnt_q == half)                  samples_d[1] = rx_in;
      if (edge_cnt_q == half + PRESCALE_W'(1)) samples_d[2] = rx_in;
    end

    if (!data_phase) begin
      bit_cnt_d = '0;
    end else if (run && last_edge) begin
      bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      samples_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      samples_q  <= samples_d;
    end
  end

  // The last sample lands at half+1, so the vote is settled from half+2 to the end of the bit.
  assign sampled_bit = majority3(samples_q);
  assign edge_cnt    = edge_cnt_q;
  assign bit_cnt     = bit_cnt_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: frame FSM, LSB-first deserializer, parity and stop checks,
// and registered result/error strobes.
module uart_rx
  import uart_pkg::*;
(
  input  logic     CLK,
  input  logic     RSTn,
  uart_rx_if.slave bus
);

  rx_state_e             state_q, state_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic                  bad_q, bad_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [DATA_W-1:0]     p_data_q, p_data_d;
  logic                  data_vld_q, data_vld_d;
  logic                  str_err_q, str_err_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;

  logic                  sampled_bit;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [PRESCALE_W-1:0] eff_prescale;
  logic                  run;
  logic                  last_edge;
  logic                  exp_parity;

  // The cycle that leaves IDLE is already edge 0, before the frame config has been latched.
  assign eff_prescale = (state_q == IDLE) ? bus.prescale : prescale_q;
  assign run          = (state_q != IDLE) || !bus.RX_IN;
  assign last_edge    = (edge_cnt == eff_prescale - PRESCALE_W'(1));
  assign exp_parity   = (^shift_q) ^ (par_typ_q == PAR_ODD);

  uart_rx_sampler u_sampler (
    .clk         (CLK),
    .rst_n       (RSTn),
    .run         (run),
    .data_phase  (state_q == DATA),
    .rx_in       (bus.RX_IN),
    .prescale    (eff_prescale),
    .sampled_bit (sampled_bit),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bad_d      = bad_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    prescale_d = prescale_q;
    p_data_d   = p_data_q;
    data_vld_d = 1'b0;
    str_err_d  = 1'b0;
    par_err_d  = 1'b0;
    stp_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        bad_d = 1'b0;
        if (!bus.RX_IN) begin
          state_d    = START;
          par_en_d   = bus.PAR_EN;
          par_typ_d  = bus.PAR_TYP;
          prescale_d = bus.prescale;
        end
      end
      START: if (last_edge) begin
        if (sampled_bit) begin
          str_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = DATA;
        end
      end
      DATA: if (last_edge) begin
        shift_d[bit_cnt] = sampled_bit;
        if (bit_cnt == BIT_CNT_W'(DATA_W - 1)) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: if (last_edge) begin
        // A parity failure is reported now, but the frame still runs through its stop bit.
        if (sampled_bit != exp_parity) begin
          par_err_d = 1'b1;
          bad_d     = 1'b1;
        end
        state_d = STOP;
      end
      STOP: if (last_edge) begin
        if (!sampled_bit) begin
          stp_err_d = 1'b1;
        end else if (!bad_q) begin
          p_data_d   = shift_q;
          data_vld_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bad_q      <= 1'b0;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      prescale_q <= '0;
      p_data_q   <= '0;
      data_vld_q <= 1'b0;
      str_err_q  <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bad_q      <= bad_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      prescale_q <= prescale_d;
      p_data_q   <= p_data_d;
      data_vld_q <= data_vld_d;
      str_err_q  <= str_err_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

  assign bus.P_DATA   = p_data_q;
  assign bus.DATA_VLD = data_vld_q;
  assign bus.STR_ERR  = str_err_q;
  assign bus.PAR_ERR  = par_err_q;
  assign bus.STP_ERR  = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: hand-built frames at several prescales, with strobe
// counts, received bytes and latency compared against hand-computed values.
module tb_uart_rx;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  uart_rx_if bus ();

  uart_rx dut (
    .CLK  (clk),
    .RSTn (rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  int         vld_n = 0, str_n = 0, par_n = 0, stp_n = 0;
  int         base_vld = 0, base_str = 0, base_par = 0, base_stp = 0;
  logic [7:0] rx_q[$];
  int         vld_cyc_q[$];
  int         last_start = 0;
  int         t1_start = 0;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.DATA_VLD) begin
      vld_n++;
      rx_q.push_back(bus.P_DATA);
      vld_cyc_q.push_back(cyc);
    end
    if (bus.STR_ERR) str_n++;
    if (bus.PAR_ERR) par_n++;
    if (bus.STP_ERR) stp_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_counts(input string tag, input int v, input int s, input int p, input int t);
    check({tag, "_vld"}, vld_n - base_vld, v);
    check({tag, "_str"}, str_n - base_str, s);
    check({tag, "_par"}, par_n - base_par, p);
    check({tag, "_stp"}, stp_n - base_stp, t);
    base_vld = vld_n;
    base_str = str_n;
    base_par = par_n;
    base_stp = stp_n;
  endtask

  // Callers are always 1 time unit after a rising edge; every task keeps that alignment.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input bit with_par, input bit par_bit,
                            input bit stop_bit, input bit scramble);
    logic [10:0] bits;
    int          n;
    int          ps;
    ps        = int'(bus.prescale);
    bits[0]   = 1'b0;
    bits[8:1] = data;
    if (with_par) begin
      bits[9]  = par_bit;
      bits[10] = stop_bit;
      n        = 11;
    end else begin
      bits[9]  = stop_bit;
      bits[10] = 1'b1;
      n        = 10;
    end
    last_start = cyc;
    for (int i = 0; i < n; i++) begin
      bus.RX_IN = bits[i];
      if (scramble && i == 1) begin
        bus.PAR_EN   = ~bus.PAR_EN;
        bus.prescale = 6'd16;
      end
      repeat (ps) @(posedge clk);
      #1;
    end
    bus.RX_IN = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    bus.RX_IN    = 1'b1;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = 1'b0;
    bus.prescale = 6'd8;
    idle(3);

    check("rst_pdata", 32'(bus.P_DATA), 32'h00);
    check("rst_vld",   32'(bus.DATA_VLD), 32'h0);
    check("rst_str",   32'(bus.STR_ERR), 32'h0);
    check("rst_par",   32'(bus.PAR_ERR), 32'h0);
    check("rst_stp",   32'(bus.STP_ERR), 32'h0);

    rst_n = 1'b1;
    idle(2);

    // prescale 8: even-parity 0xAD, then 0x98 back-to-back with config wiggled mid-frame.
    bus.PAR_EN  = 1'b1;
    bus.PAR_TYP = 1'b0;
    send_frame(8'hAD, 1'b1, 1'b1, 1'b1, 1'b0);
    t1_start   = last_start;
    bus.PAR_EN = 1'b0;
    send_frame(8'h98, 1'b0, 1'b0, 1'b1, 1'b1);
    bus.PAR_EN   = 1'b0;
    bus.prescale = 6'd8;
    idle(2);
    expect_counts("p8", 2, 0, 0, 0);
    check("p8_byte0",   32'(rx_q[0]), 32'hAD);
    check("p8_byte1",   32'(rx_q[1]), 32'h98);
    check("p8_latency", vld_cyc_q[0] - t1_start, 88);
    check("p8_pdata",   32'(bus.P_DATA), 32'h98);

    // prescale 16: odd-parity 0x75, then no-parity 0xD1.
    bus.prescale = 6'd16;
    bus.PAR_EN   = 1'b1;
    bus.PAR_TYP  = 1'b1;
    send_frame(8'h75, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.PAR_EN = 1'b0;
    send_frame(8'hD1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    expect_counts("p16", 2, 0, 0, 0);
    check("p16_byte0", 32'(rx_q[2]), 32'h75);
    check("p16_byte1", 32'(rx_q[3]), 32'hD1);
    check("p16_lat1",  vld_cyc_q[3] - last_start, 160);

    // prescale 32: even-parity 0xDE, then no-parity 0x75.
    bus.prescale = 6'd32;
    bus.PAR_EN   = 1'b1;
    bus.PAR_TYP  = 1'b0;
    send_frame(8'hDE, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.PAR_EN = 1'b0;
    send_frame(8'h75, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    expect_counts("p32", 2, 0, 0, 0);
    check("p32_byte0", 32'(rx_q[4]), 32'hDE);
    check("p32_byte1", 32'(rx_q[5]), 32'h75);

    // prescale 8, even parity: 0xB6 has five ones, so parity bit 0 is wrong.
    bus.prescale = 6'd8;
    bus.PAR_EN   = 1'b1;
    bus.PAR_TYP  = 1'b0;
    send_frame(8'hB6, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    expect_counts("perr", 0, 0, 1, 0);
    check("perr_pdata", 32'(bus.P_DATA), 32'h75);

    // prescale 32: quarter-bit glitch, then odd-parity 0x5A with a low stop bit.
    bus.prescale = 6'd32;
    bus.RX_IN    = 1'b0;
    idle(8);
    bus.RX_IN = 1'b1;
    idle(40);
    expect_counts("glitch", 0, 1, 0, 0);
    bus.PAR_EN  = 1'b1;
    bus.PAR_TYP = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    expect_counts("serr", 0, 0, 0, 1);
    check("serr_pdata", 32'(bus.P_DATA), 32'h75);

    // Line still low after a bad stop bit is taken as the next start bit.
    bus.prescale = 6'd8;
    bus.PAR_EN   = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    expect_counts("relow", 1, 0, 0, 1);
    check("relow_pdata", 32'(bus.P_DATA), 32'hFF);

    // Reset in the middle of a frame, then a clean frame.
    bus.RX_IN = 1'b0;
    idle(30);
    rst_n = 1'b0;
    #1;
    check("mrst_pdata", 32'(bus.P_DATA), 32'h00);
    check("mrst_vld",   32'(bus.DATA_VLD), 32'h0);
    bus.RX_IN = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(4);
    expect_counts("mrst", 0, 0, 0, 0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    expect_counts("recov", 1, 0, 0, 0);
    check("recov_pdata", 32'(bus.P_DATA), 32'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
